seq_addsub_acc: RTL and testbench

SEQ_ADDSUB_ACC -- requirements
Module: seq_addsub_acc

---
 rtl/seq_addsub_acc_if.sv | 35 +++
 rtl/seq_addsub_acc.sv | 123 ++++++++++++
 tb/tb_seq_addsub_acc.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_addsub_acc_if.sv
// Operand/result bundle for the sequential add/subtract accumulator.
// Latency: none, this is wiring only.
// Backpressure: none; the master drives operands and the slave always accepts them.
interface seq_addsub_acc_if #(
  parameter int WIDTH        = 8,
  parameter int NUM_OPERANDS = 2
);
  localparam int CW = $clog2(NUM_OPERANDS + 1);

  // Operand side
  logic             in_vld;
  logic [WIDTH-1:0] in_dat;
  logic             mode;
  logic             clear;

  // Result side
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             ovf;
  logic             busy;
  logic             done;
  logic [CW-1:0]    op_count;

  // Operand producer (testbench / upstream logic)
  modport master (
    output in_vld, in_dat, mode, clear,
    input  result, carry, ovf, busy, done, op_count
  );

  // Accumulator
  modport slave (
    input  in_vld, in_dat, mode, clear,
    output result, carry, ovf, busy, done, op_count
  );
endinterface

// File: rtl/seq_addsub_acc.sv
// Sequential add/subtract accumulator over NUM_OPERANDS operands; SEQ_ADDSUB_SAT_EN selects unsigned saturation.
// Latency: one cycle per accepted operand; Done is high the cycle after the last operand.
// Backpressure: none, every in_vld cycle is consumed; clear aborts and wins over in_vld.
module seq_addsub_acc #(
  parameter int WIDTH        = 8,
  parameter int NUM_OPERANDS = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  seq_addsub_acc_if.slave  io_bus
);

  localparam int CW = $clog2(NUM_OPERANDS + 1);
  localparam int M  = WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;
  logic [CW-1:0]    r_op_count;

  logic [WIDTH:0]   w_a_ext;
  logic [WIDTH:0]   w_b_ext;
  logic [WIDTH:0]   w_raw;
  logic             w_cy;
  logic             w_ovf;
  logic [WIDTH-1:0] w_next;
  logic             w_last;

  // Datapath: one WIDTH+1 bit add or subtract; the top bit is carry (add) or borrow (sub).
  always_comb begin
    w_a_ext = {1'b0, r_result};
    w_b_ext = {1'b0, io_bus.in_dat};
    w_raw   = io_bus.mode ? (w_a_ext - w_b_ext) : (w_a_ext + w_b_ext);
    w_cy    = w_raw[WIDTH];
    // Signed overflow: add flips when like-signed operands give an unlike result,
    // subtract flips when unlike-signed operands give a result unlike the minuend.
    if (io_bus.mode)
      w_ovf = (r_result[M] != io_bus.in_dat[M]) && (w_raw[M] != r_result[M]);
    else
      w_ovf = (r_result[M] == io_bus.in_dat[M]) && (w_raw[M] != r_result[M]);
`ifdef SEQ_ADDSUB_SAT_EN
    // Unsigned saturation: clamp to all-ones on carry, to zero on borrow.
    if (w_cy)
      w_next = io_bus.mode ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
    else
      w_next = w_raw[WIDTH-1:0];
`else
    w_next  = w_raw[WIDTH-1:0];
`endif
    w_last  = (r_op_count == CW'(NUM_OPERANDS - 1));
  end

  // Control FSM with registered status outputs; first operand loads, later ones accumulate.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_op_count <= '0;
    end else if (io_bus.clear) begin
      r_state    <= S_IDLE;
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_op_count <= '0;
    end else if (io_bus.in_vld) begin
      case (r_state)
        S_IDLE, S_DONE: begin
          // Mode is not looked at for the first operand.
          r_state    <= S_ACCUM;
          r_result   <= io_bus.in_dat;
          r_carry    <= 1'b0;
          r_ovf      <= 1'b0;
          r_busy     <= 1'b1;
          r_done     <= 1'b0;
          r_op_count <= CW'(1);
        end
        S_ACCUM: begin
          r_result   <= w_next;
          r_carry    <= w_cy;
          r_ovf      <= r_ovf | w_ovf;
          r_op_count <= r_op_count + CW'(1);
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_result   <= '0;
          r_carry    <= 1'b0;
          r_ovf      <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_op_count <= '0;
        end
      endcase
    end
  end

  assign io_bus.result   = r_result;
  assign io_bus.carry    = r_carry;
  assign io_bus.ovf      = r_ovf;
  assign io_bus.busy     = r_busy;
  assign io_bus.done     = r_done;
  assign io_bus.op_count = r_op_count;

endmodule

// File: tb/tb_seq_addsub_acc.sv
// Directed bench for seq_addsub_acc: 8-bit/2-op, 8-bit/4-op and 16-bit/2-op instances.
// Latency: checks are taken on the falling edge after each operand edge.
// Backpressure: none; operands are driven one per selected cycle.
module tb_seq_addsub_acc;

`ifdef SEQ_ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  seq_addsub_acc_if #(.WIDTH(8),  .NUM_OPERANDS(2)) ifa ();
  seq_addsub_acc_if #(.WIDTH(8),  .NUM_OPERANDS(4)) ifb ();
  seq_addsub_acc_if #(.WIDTH(16), .NUM_OPERANDS(2)) ifc ();

  seq_addsub_acc #(.WIDTH(8),  .NUM_OPERANDS(2)) u_a (.i_clk(clk), .i_rst(rst), .io_bus(ifa.slave));
  seq_addsub_acc #(.WIDTH(8),  .NUM_OPERANDS(4)) u_b (.i_clk(clk), .i_rst(rst), .io_bus(ifb.slave));
  seq_addsub_acc #(.WIDTH(16), .NUM_OPERANDS(2)) u_c (.i_clk(clk), .i_rst(rst), .io_bus(ifc.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic a_op(input logic [7:0] d, input logic m, input logic clr);
    @(negedge clk);
    ifa.in_vld = 1'b1;
    ifa.in_dat = d;
    ifa.mode   = m;
    ifa.clear  = clr;
    @(negedge clk);
    ifa.in_vld = 1'b0;
    ifa.clear  = 1'b0;
  endtask

  task automatic b_op(input logic [7:0] d, input logic m);
    @(negedge clk);
    ifb.in_vld = 1'b1;
    ifb.in_dat = d;
    ifb.mode   = m;
    @(negedge clk);
    ifb.in_vld = 1'b0;
  endtask

  task automatic c_op(input logic [15:0] d, input logic m);
    @(negedge clk);
    ifc.in_vld = 1'b1;
    ifc.in_dat = d;
    ifc.mode   = m;
    @(negedge clk);
    ifc.in_vld = 1'b0;
  endtask

  task automatic a_all_zero(input string tag);
    chk({tag, "_res"},  32'(ifa.result),   32'h0);
    chk({tag, "_cy"},   32'(ifa.carry),    32'h0);
    chk({tag, "_ovf"},  32'(ifa.ovf),      32'h0);
    chk({tag, "_busy"}, 32'(ifa.busy),     32'h0);
    chk({tag, "_done"}, 32'(ifa.done),     32'h0);
    chk({tag, "_cnt"},  32'(ifa.op_count), 32'h0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    ifa.in_vld = 1'b0; ifa.in_dat = '0; ifa.mode = 1'b0; ifa.clear = 1'b0;
    ifb.in_vld = 1'b0; ifb.in_dat = '0; ifb.mode = 1'b0; ifb.clear = 1'b0;
    ifc.in_vld = 1'b0; ifc.in_dat = '0; ifc.mode = 1'b0; ifc.clear = 1'b0;
    #12;
    a_all_zero("rst");
    chk("rst_b_cnt", 32'(ifb.op_count), 32'h0);
    chk("rst_c_res", 32'(ifc.result),   32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Signed overflow on add
    a_op(8'h7F, 1'b0, 1'b0);
    chk("ovf1_res", 32'(ifa.result),   32'h7F);
    chk("ovf1_cnt", 32'(ifa.op_count), 32'd1);
    chk("ovf1_busy", 32'(ifa.busy),    32'h1);
    chk("ovf1_done", 32'(ifa.done),    32'h0);
    a_op(8'h01, 1'b0, 1'b0);
    chk("ovf2_res",  32'(ifa.result),   32'h80);
    chk("ovf2_cy",   32'(ifa.carry),    32'h0);
    chk("ovf2_ovf",  32'(ifa.ovf),      32'h1);
    chk("ovf2_done", 32'(ifa.done),     32'h1);
    chk("ovf2_busy", 32'(ifa.busy),     32'h0);
    chk("ovf2_cnt",  32'(ifa.op_count), 32'd2);

    // Back-to-back restart from DONE; mode ignored for first operand
    a_op(8'h33, 1'b1, 1'b0);
    chk("b2b_res",  32'(ifa.result),   32'h33);
    chk("b2b_cnt",  32'(ifa.op_count), 32'd1);
    chk("b2b_ovf",  32'(ifa.ovf),      32'h0);
    chk("b2b_done", 32'(ifa.done),     32'h0);
    chk("b2b_busy", 32'(ifa.busy),     32'h1);

    // Clear together with an operand: clear wins
    a_op(8'h44, 1'b0, 1'b1);
    a_all_zero("clr");

    // Subtract with borrow
    a_op(8'h05, 1'b0, 1'b0);
    a_op(8'h07, 1'b1, 1'b0);
    chk("sub_res",  32'(ifa.result), SAT ? 32'h00 : 32'hFE);
    chk("sub_cy",   32'(ifa.carry),  32'h1);
    chk("sub_ovf",  32'(ifa.ovf),    32'h0);
    chk("sub_done", 32'(ifa.done),   32'h1);

    // Unsigned wrap on add
    a_op(8'hFF, 1'b0, 1'b0);
    a_op(8'h01, 1'b0, 1'b0);
    chk("wrap_res", 32'(ifa.result), SAT ? 32'hFF : 32'h00);
    chk("wrap_cy",  32'(ifa.carry),  32'h1);
    chk("wrap_ovf", 32'(ifa.ovf),    32'h0);

    // Signed overflow on subtract
    a_op(8'h80, 1'b0, 1'b0);
    a_op(8'h01, 1'b1, 1'b0);
    chk("sovf_res", 32'(ifa.result), 32'h7F);
    chk("sovf_cy",  32'(ifa.carry),  32'h0);
    chk("sovf_ovf", 32'(ifa.ovf),    32'h1);

    // Four-operand sequence with idle gaps
    b_op(8'd10, 1'b1);
    chk("n4_cnt1",  32'(ifb.op_count), 32'd1);
    chk("n4_res1",  32'(ifb.result),   32'd10);
    repeat (3) @(negedge clk);
    chk("n4_hold_cnt", 32'(ifb.op_count), 32'd1);
    chk("n4_hold_res", 32'(ifb.result),   32'd10);
    b_op(8'd20, 1'b0);
    chk("n4_cnt2",  32'(ifb.op_count), 32'd2);
    repeat (2) @(negedge clk);
    b_op(8'd30, 1'b0);
    chk("n4_cnt3",  32'(ifb.op_count), 32'd3);
    chk("n4_busy3", 32'(ifb.busy),     32'h1);
    chk("n4_done3", 32'(ifb.done),     32'h0);
    b_op(8'd5, 1'b1);
    chk("n4_cnt4",  32'(ifb.op_count), 32'd4);
    chk("n4_res4",  32'(ifb.result),   32'd55);
    chk("n4_cy4",   32'(ifb.carry),    32'h0);
    chk("n4_busy4", 32'(ifb.busy),     32'h0);
    chk("n4_done4", 32'(ifb.done),     32'h1);

    // 16-bit wrap
    c_op(16'hFFFF, 1'b0);
    c_op(16'h0001, 1'b0);
    chk("w16_res",  32'(ifc.result), SAT ? 32'hFFFF : 32'h0000);
    chk("w16_cy",   32'(ifc.carry),  32'h1);
    chk("w16_ovf",  32'(ifc.ovf),    32'h0);
    chk("w16_done", 32'(ifc.done),   32'h1);

    // Asynchronous reset mid-sequence, between clock edges
    a_op(8'h42, 1'b0, 1'b0);
    chk("mid_cnt", 32'(ifa.op_count), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    a_all_zero("arst");
    chk("arst_b_done", 32'(ifb.done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    ifa.in_vld = 1'b1;
    ifa.in_dat = 8'h10;
    ifa.mode   = 1'b0;
    @(negedge clk);
    ifa.in_vld = 1'b0;
    chk("post_cnt1", 32'(ifa.op_count), 32'd1);
    chk("post_res1", 32'(ifa.result),   32'h10);
    a_op(8'h20, 1'b0, 1'b0);
    chk("post_res2",  32'(ifa.result), 32'h30);
    chk("post_done2", 32'(ifa.done),   32'h1);
    chk("post_ovf2",  32'(ifa.ovf),    32'h0);

    // Clear alone during accumulation
    a_op(8'h55, 1'b0, 1'b0);
    @(negedge clk);
    ifa.clear = 1'b1;
    @(negedge clk);
    ifa.clear = 1'b0;
    a_all_zero("clr2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
